playfield_tracker: RTL and testbench
====================================

// Module: playfield_tracker
// PURPOSE
//  Upstream stage of the victory detector in the ddr-rhythm tug-of-war game.
//  - Synchronises the raw L/R player keys and converts them to one-cycle press events.
//  - Moves a single lit position across LEDR[9:1]: L presses move it toward LEDR9, R presses toward LEDR1.
//  - Drives the downstream victory stage: LEDR[1] and LEDR[9] feed its LEDR1/LEDR9 inputs, left_evt/right_evt feed its L/R inputs.
// PARAMETERS
//  NUM_LIGHTS      9   number of playfield lights; LEDR index range is 1..NUM_LIGHTS
//  CENTER          5   reset position; legal range 1..NUM_LIGHTS
//  SYNC_STAGES     2   flop depth of each key synchroniser; minimum 2
//  HOLDOFF_CYCLES  16  per-side lockout after an accepted press; minimum 1; used only with PRESS_HOLDOFF_EN
// PORTS
//  clk        in   1           system clock; all state changes on posedge
//  reset      in   1           synchronous, active-high
//  L          in   1           raw left-player key, active-high, asynchronous to clk
//  R          in   1           raw right-player key, active-high, asynchronous to clk
//  game_over  in   1           1 = freeze the position (victory declared downstream)
//  LEDR       out  NUM_LIGHTS  one-hot position; bit i-1 lights LEDR(i)
//  left_evt   out  1           one-cycle pulse per accepted L press
//  right_evt  out  1           one-cycle pulse per accepted R press
// BEHAVIOUR
//  Reset (checked on posedge clk when reset=1)
//  - Clears all synchroniser flops, edge-history flops and holdoff counters to 0.
//  - Sets pos=CENTER, so LEDR = one-hot CENTER.
//  - Forces left_evt=0 and right_evt=0.
//  - A reset mid-game takes effect on the next edge, overriding any event in the same cycle.
//  Input path
//  - Each key passes through SYNC_STAGES flops: s = last stage, p = s delayed by one cycle.
//  - Raw press: rise = s & ~p.
//  - Latency: a key 0->1 transition held through SYNC_STAGES+1 edges produces the event pulse and pos update on the same edge.
//  - A held key yields exactly one event. A release generates no event.
//  Qualification (evaluated per cycle, in this order)
//  - Left accepted:  rise_L & ~rise_R & lockout_L==0.
//  - Right accepted: rise_R & ~rise_L & lockout_R==0.
//  - Simultaneous rise_L and rise_R in the same cycle: both dropped; no event, no move.
//  - Accepted events pulse left_evt/right_evt for exactly one cycle, registered outputs.
//  - Events still pulse while game_over=1.
//  Position update, on accepted events only
//  - Left and pos<NUM_LIGHTS: pos+1. Left and pos==NUM_LIGHTS: pos holds; the event still pulses, so downstream sees LEDR9 & L.
//  - Right and pos>1: pos-1. Right and pos==1: pos holds; the event still pulses.
//  - game_over=1: pos never changes.
//  - pos has width $clog2(NUM_LIGHTS+1) and never leaves 1..NUM_LIGHTS.
//  - LEDR is decoded from the registered pos and is always exactly one-hot.
// CONFIGURATION
//  PRESS_HOLDOFF_EN defined
//  - Each side has its own down-counter, wide enough for HOLDOFF_CYCLES.
//  - An accepted event on a side loads that side's counter with HOLDOFF_CYCLES-1.
//  - The counter decrements each cycle until it reaches 0.
//  - A rise on a side whose counter is nonzero is dropped, not queued.
//  - Counters keep running while game_over=1.
//  PRESS_HOLDOFF_EN undefined
//  - No counters are built; lockout_L and lockout_R are constant 0.
//  - Every qualified rising edge is accepted.
// TESTING (SYNC_STAGES=2, NUM_LIGHTS=9, CENTER=5)
//  - Reset: hold reset for 2 cycles -> LEDR=9'b000010000, left_evt=0, right_evt=0.
//  - Latency and move: L 0->1 and held -> left_evt=1 for exactly one cycle on the 3rd edge, pos=6, LEDR=9'b000100000; keeping L high gives no further events.
//  - Upper bound: 5 separate L presses from reset -> pos=9 after the 4th; the 5th pulses left_evt and pos stays at 9.
//    Lower bound: 5 separate R presses from reset -> pos=1 after the 4th; the 5th pulses right_evt and pos stays at 1.
//  - Simultaneous: L and R rise on the same cycle -> no event pulses, pos stays at 5.
//  - Freeze: game_over=1 then an R press -> right_evt pulses and LEDR is unchanged.
//    Reset asserted in the same cycle as an accepted L press -> pos=5 and no event pulse.
//  - PRESS_HOLDOFF_EN, HOLDOFF_CYCLES=16: L pressed twice, 5 cycles apart -> one event, pos=6.
//    Second press 20 cycles after the first -> two events, pos=7.
//    An R press during the L lockout is accepted.

Source files
------------

// File: rtl/playfield_tracker_if.sv
// Player-side bus of the tug-of-war playfield tracker: raw keys and freeze in,
// one-hot lights and press events out.
interface playfield_tracker_if #(
  parameter int NUM_LIGHTS = 9
);
  logic                  L;
  logic                  R;
  logic                  game_over;
  logic [NUM_LIGHTS-1:0] LEDR;
  logic                  left_evt;
  logic                  right_evt;

  modport master (output L, R, game_over, input LEDR, left_evt, right_evt);
  modport slave  (input L, R, game_over, output LEDR, left_evt, right_evt);
endinterface

// File: rtl/playfield_tracker.sv
// Playfield tracker: synchronises L/R keys, turns rises into press events and walks
// a one-hot light across LEDR. Optional per-side press lockout: define PRESS_HOLDOFF_EN.
module playfield_tracker #(
  parameter int NUM_LIGHTS     = 9,
  parameter int CENTER         = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  playfield_tracker_if.slave bus
);
  localparam int PW = $clog2(NUM_LIGHTS + 1);

  if (SYNC_STAGES < 2 || CENTER < 1 || CENTER > NUM_LIGHTS || HOLDOFF_CYCLES < 1) begin : g_bad_param
    $error("playfield_tracker: illegal parameter set");
  end

  // Side index 0 = left key, 1 = right key.
  logic [1:0]                  keys;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  prev_q;
  logic [1:0]                  rise;
  logic [1:0]                  lock;
  logic [1:0]                  acc;
  logic [1:0]                  evt_q;
  logic [PW-1:0]               pos_q, pos_d;
  logic [NUM_LIGHTS-1:0]       led;

  assign keys = {bus.R, bus.L};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
      pos_q  <= PW'(CENTER);
    end else begin
      for (int k = 0; k < 2; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], keys[k]};
        prev_q[k] <= sync_q[k][SYNC_STAGES-1];
      end
      evt_q <= acc;
      pos_q <= pos_d;
    end
  end

  always_comb begin
    rise = '0;
    for (int k = 0; k < 2; k++) rise[k] = sync_q[k][SYNC_STAGES-1] & ~prev_q[k];
  end

  // Simultaneous rises cancel each other; a locked side drops its rise.
  assign acc[0] = rise[0] & ~rise[1] & ~lock[0];
  assign acc[1] = rise[1] & ~rise[0] & ~lock[1];

`ifdef PRESS_HOLDOFF_EN
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [1:0][HW-1:0] hold_q, hold_d;

  always_comb begin
    lock = '0;
    for (int k = 0; k < 2; k++) lock[k] = (hold_q[k] != '0);
  end

  always_comb begin
    hold_d = hold_q;
    for (int k = 0; k < 2; k++) begin
      if (acc[k])               hold_d[k] = HW'(HOLDOFF_CYCLES - 1);
      else if (hold_q[k] != '0) hold_d[k] = hold_q[k] - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign lock = '0;
`endif

  // Events at the ends still pulse so the victory stage sees LEDR9&L / LEDR1&R.
  always_comb begin
    pos_d = pos_q;
    if (!bus.game_over) begin
      if (acc[0] && pos_q < PW'(NUM_LIGHTS)) pos_d = pos_q + PW'(1);
      else if (acc[1] && pos_q > PW'(1))     pos_d = pos_q - PW'(1);
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) led[i] = (pos_q == PW'(i + 1));
  end

  assign bus.LEDR      = led;
  assign bus.left_evt  = evt_q[0];
  assign bus.right_evt = evt_q[1];
endmodule

// File: tb/tb_playfield_tracker.sv
// Self-checking bench for playfield_tracker: directed scenarios plus randomized key
// activity, all compared against an edge-indexed behavioural model.
module tb_playfield_tracker;
  localparam int NL = 9;
  localparam int CE = 5;
  localparam int SS = 2;
  localparam int HC = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playfield_tracker_if #(.NUM_LIGHTS(NL)) bus();

  playfield_tracker #(
    .NUM_LIGHTS(NL), .CENTER(CE), .SYNC_STAGES(SS), .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model: raw key samples per edge, position, last accepted edge per side.
  bit hl [0:8191];
  bit hr [0:8191];
  int n      = 16;
  int m_pos  = CE;
  bit m_el, m_er;
  int lastL  = -100000;
  int lastR  = -100000;
  int obsL   = 0;
  int obsR   = 0;
  bit go_v   = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic model_step(bit rs, bit l, bit r, bit go);
    bit rl, rr, lkL, lkR, aL, aR;
    n++;
    if (rs) begin
      m_pos = CE; m_el = 0; m_er = 0;
      for (int k = 0; k <= SS; k++) begin hl[n-k] = 0; hr[n-k] = 0; end
      lastL = -100000; lastR = -100000;
    end else begin
      rl = hl[n-SS] & ~hl[n-SS-1];
      rr = hr[n-SS] & ~hr[n-SS-1];
      hl[n] = l; hr[n] = r;
`ifdef PRESS_HOLDOFF_EN
      lkL = (n - lastL) < HC;
      lkR = (n - lastR) < HC;
`else
      lkL = 0; lkR = 0;
`endif
      aL = rl & ~rr & ~lkL;
      aR = rr & ~rl & ~lkR;
      if (aL) lastL = n;
      if (aR) lastR = n;
      m_el = aL; m_er = aR;
      if (!go) begin
        if (aL && m_pos < NL)     m_pos++;
        else if (aR && m_pos > 1) m_pos--;
      end
    end
  endtask

  task automatic cyc(bit rs, bit l, bit r, bit go);
    reset = rs; bus.L = l; bus.R = r; bus.game_over = go;
    @(posedge clk);
    #1;
    model_step(rs, l, r, go);
    check("ledr", 32'(bus.LEDR), 32'(1) << (m_pos - 1));
    check("left_evt", 32'(bus.left_evt), 32'(m_el));
    check("right_evt", 32'(bus.right_evt), 32'(m_er));
    if (bus.left_evt === 1'b1)  obsL++;
    if (bus.right_evt === 1'b1) obsR++;
  endtask

  task automatic press(bit l, bit r, int hi, int lo);
    for (int i = 0; i < hi; i++) cyc(0, l, r, go_v);
    for (int i = 0; i < lo; i++) cyc(0, 0, 0, go_v);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    go_v = 0;
  endtask

  int b0, b1;
  bit kl, kr, kg, krs;

  initial begin
    reset = 1; bus.L = 0; bus.R = 0; bus.game_over = 0;

    do_reset();
    check("reset_ledr", 32'(bus.LEDR), 32'h010);
    check("reset_levt", 32'(bus.left_evt), 32'd0);
    check("reset_revt", 32'(bus.right_evt), 32'd0);

    // Latency: event on the 3rd edge after L rises, held key gives one event.
    b0 = obsL;
    cyc(0, 1, 0, 0); check("lat_e1", 32'(bus.left_evt), 32'd0);
    cyc(0, 1, 0, 0); check("lat_e2", 32'(bus.left_evt), 32'd0);
    cyc(0, 1, 0, 0); check("lat_e3", 32'(bus.left_evt), 32'd1);
    check("lat_ledr", 32'(bus.LEDR), 32'h020);
    press(1, 0, 6, 20);
    check("held_one_evt", 32'(obsL - b0), 32'd1);

    // Upper bound.
    do_reset();
    for (int i = 0; i < 4; i++) press(1, 0, 3, 17);
    check("upper_ledr4", 32'(bus.LEDR), 32'h100);
    b0 = obsL;
    press(1, 0, 3, 17);
    check("upper_evt5", 32'(obsL - b0), 32'd1);
    check("upper_ledr5", 32'(bus.LEDR), 32'h100);

    // Lower bound.
    do_reset();
    for (int i = 0; i < 4; i++) press(0, 1, 3, 17);
    check("lower_ledr4", 32'(bus.LEDR), 32'h001);
    b0 = obsR;
    press(0, 1, 3, 17);
    check("lower_evt5", 32'(obsR - b0), 32'd1);
    check("lower_ledr5", 32'(bus.LEDR), 32'h001);

    // Simultaneous rise.
    do_reset();
    b0 = obsL; b1 = obsR;
    press(1, 1, 3, 17);
    check("simul_evts", 32'(obsL - b0 + obsR - b1), 32'd0);
    check("simul_ledr", 32'(bus.LEDR), 32'h010);

    // Freeze: event pulses, position held.
    go_v = 1;
    b1 = obsR;
    press(0, 1, 3, 17);
    check("freeze_evt", 32'(obsR - b1), 32'd1);
    check("freeze_ledr", 32'(bus.LEDR), 32'h010);
    go_v = 0;

    // Reset coinciding with an accepted L press.
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("rstcoll_evt", 32'(bus.left_evt), 32'd0);
    check("rstcoll_ledr", 32'(bus.LEDR), 32'h010);
    press(0, 0, 0, 6);

    // Two presses 5 cycles apart.
    do_reset();
    b0 = obsL;
    press(1, 0, 2, 3);
    press(1, 0, 3, 20);
`ifdef PRESS_HOLDOFF_EN
    check("hold5_evts", 32'(obsL - b0), 32'd1);
    check("hold5_ledr", 32'(bus.LEDR), 32'h020);

    do_reset();
    b0 = obsL;
    press(1, 0, 3, 17);
    press(1, 0, 3, 20);
    check("hold20_evts", 32'(obsL - b0), 32'd2);
    check("hold20_ledr", 32'(bus.LEDR), 32'h040);

    do_reset();
    b1 = obsR;
    press(1, 0, 3, 1);
    press(0, 1, 3, 17);
    check("hold_r_evt", 32'(obsR - b1), 32'd1);
    check("hold_r_ledr", 32'(bus.LEDR), 32'h010);
`else
    check("nohold_evts", 32'(obsL - b0), 32'd2);
    check("nohold_ledr", 32'(bus.LEDR), 32'h040);
`endif

    // Randomized key activity with occasional freeze and reset.
    kl = 0; kr = 0; kg = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0)  kl = ~kl;
      if ($urandom_range(0, 5) == 0)  kr = ~kr;
      if ($urandom_range(0, 60) == 0) kg = ~kg;
      krs = ($urandom_range(0, 300) == 0);
      cyc(krs, kl, kr, kg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
